// File: rtl/seg_display_capture_pkg.sv
// seg_pkg: shared constants and decode helpers for the 7-segment capture path.
// Contents: active-low segment patterns (order a..g, a in bit 6) for hex chars
// 0..F, one-hot-low anode codes per digit, the default stability dwell, and
// helper functions that turn a segment pattern into {valid, char} and an
// anode word into {legal, digit index}.
package seg_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  typedef struct packed {
    logic       valid;
    logic [3:0] ch;
  } seg_dec_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
  } an_dec_t;

  // Segment pattern -> hex char; anything outside the 16 glyphs is invalid.
  function automatic seg_dec_t seg_decode(input logic [6:0] pat);
    seg_dec_t r;
    r.valid = 1'b1;
    r.ch    = 4'h0;
    case (pat)
      SEG_0:   r.ch = 4'h0;
      SEG_1:   r.ch = 4'h1;
      SEG_2:   r.ch = 4'h2;
      SEG_3:   r.ch = 4'h3;
      SEG_4:   r.ch = 4'h4;
      SEG_5:   r.ch = 4'h5;
      SEG_6:   r.ch = 4'h6;
      SEG_7:   r.ch = 4'h7;
      SEG_8:   r.ch = 4'h8;
      SEG_9:   r.ch = 4'h9;
      SEG_A:   r.ch = 4'hA;
      SEG_B:   r.ch = 4'hB;
      SEG_C:   r.ch = 4'hC;
      SEG_D:   r.ch = 4'hD;
      SEG_E:   r.ch = 4'hE;
      SEG_F:   r.ch = 4'hF;
      default: begin
        r.valid = 1'b0;
        r.ch    = 4'h0;
      end
    endcase
    return r;
  endfunction

  // Anode word -> digit index; legal only with exactly one low bit.
  function automatic an_dec_t an_decode(input logic [3:0] an);
    an_dec_t r;
    r.legal = 1'b1;
    r.idx   = 2'd0;
    case (an)
      AN_DIG0: r.idx = 2'd0;
      AN_DIG1: r.idx = 2'd1;
      AN_DIG2: r.idx = 2'd2;
      AN_DIG3: r.idx = 2'd3;
      default: begin
        r.legal = 1'b0;
        r.idx   = 2'd0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_display_capture_if.sv
// seg_display_capture_if: the multiplexed display bus (active-low).
//   an  [3:0] anode lines, an[3] is the leftmost digit
//   LED [6:0] segment lines, LED[6]=a ... LED[0]=g
// master drives the bus (display driver / bench), slave observes it.
interface seg_display_capture_if;
  logic [3:0] an;
  logic [6:0] LED;

  modport master (output an, output LED);
  modport slave  (input  an, input  LED);
endinterface

// File: rtl/seg_display_capture_encoder.sv
// seg_encoder: combinational 7-segment pattern to hex char encoder.
//   pattern [6:0] in   active-low segments, a..g
//   ch      [3:0] out  decoded hex char (0 when invalid)
//   valid         out  pattern is one of the 16 hex glyphs
module seg_encoder
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] ch,
  output logic       valid
);

  seg_dec_t dec_s;

  // Table lookup lives in the package so other checkers decode identically.
  always_comb begin
    dec_s = seg_decode(pattern);
    ch    = dec_s.ch;
    valid = dec_s.valid;
  end

endmodule

// File: rtl/seg_display_capture.sv
// seg_display_capture: reconstructs the 16-bit value shown on a multiplexed
// 4-digit 7-segment display.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   bus          display bus (an, LED), slave side
//   value        last completed frame, digit 3 in [15:12]
//   err          per-digit undecodable-pattern flags of that frame
//   frame_valid  one-cycle strobe, value/err change with it
//   digit_mask   digits captured since the last frame
module seg_display_capture #(
  parameter int STABLE_CYCLES = seg_pkg::STABLE_CYCLES_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  seg_display_capture_if.slave        bus,
  output logic [15:0]                 value,
  output logic [3:0]                  err,
  output logic                        frame_valid,
  output logic [3:0]                  digit_mask
);
  import seg_pkg::*;

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [3:0]    an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_prev_q, an_prev_d;
  logic [6:0]    led_s1_q, led_s1_d, led_s2_q, led_s2_d, led_prev_q, led_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   slots_q, slots_d, value_q, value_d;
  logic [3:0]    perr_q, perr_d, mask_q, mask_d, err_q, err_d;
  logic          fv_q, fv_d;

  an_dec_t       an_info_s;
  logic [3:0]    enc_ch_s;
  logic          enc_valid_s;
  logic          same_s, accept_s, frame_s;
  logic [3:0]    hit_s, mask_base_s, perr_base_s;

  seg_encoder u_enc (
    .pattern (led_s2_q),
    .ch      (enc_ch_s),
    .valid   (enc_valid_s)
  );

  // Next-state logic: sync pipeline, dwell counter, slot/mask/frame control.
  always_comb begin
    an_s1_d    = bus.an;
    led_s1_d   = bus.LED;
    an_s2_d    = an_s1_q;
    led_s2_d   = led_s1_q;
    an_prev_d  = an_s2_q;
    led_prev_d = led_s2_q;

    an_info_s = an_decode(an_s2_q);
    same_s    = ({an_s2_q, led_s2_q} == {an_prev_q, led_prev_q});
    accept_s  = 1'b0;
    cnt_d     = cnt_q;

    // cnt_q counts repeats after the first sample of a dwell, so the
    // STABLE_CYCLES-th identical sample arrives while cnt_q is STABLE_CYCLES-2.
    if (!an_info_s.legal) begin
      cnt_d = {CW{1'b0}};
    end else if (!same_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      if (cnt_q == CW'(STABLE_CYCLES - 2)) begin
        accept_s = 1'b1;
      end else begin
        accept_s = 1'b0;
      end
      if (cnt_q < CW'(STABLE_CYCLES - 1)) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end

    hit_s   = 4'(4'b0001 << an_info_s.idx);
    frame_s = (mask_q == 4'b1111);

    // An accept coinciding with frame emission starts the next frame.
    if (frame_s) begin
      mask_base_s = 4'b0000;
      perr_base_s = 4'b0000;
    end else begin
      mask_base_s = mask_q;
      perr_base_s = perr_q;
    end

    slots_d = slots_q;
    mask_d  = mask_base_s;
    perr_d  = perr_base_s;
    if (accept_s) begin
      mask_d = mask_base_s | hit_s;
      if (enc_valid_s) begin
        perr_d = perr_base_s;
        case (an_info_s.idx)
          2'd0:    slots_d[3:0]   = enc_ch_s;
          2'd1:    slots_d[7:4]   = enc_ch_s;
          2'd2:    slots_d[11:8]  = enc_ch_s;
          2'd3:    slots_d[15:12] = enc_ch_s;
          default: slots_d        = slots_q;
        endcase
      end else begin
        perr_d = perr_base_s | hit_s;
      end
    end else begin
      mask_d = mask_base_s;
    end

    if (frame_s) begin
      value_d = slots_q;
      err_d   = perr_q;
      fv_d    = 1'b1;
    end else begin
      value_d = value_q;
      err_d   = err_q;
      fv_d    = 1'b0;
    end
  end

  // State registers, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_s1_q    <= 4'd0;
      led_s1_q   <= 7'd0;
      an_s2_q    <= 4'd0;
      led_s2_q   <= 7'd0;
      an_prev_q  <= 4'd0;
      led_prev_q <= 7'd0;
      cnt_q      <= {CW{1'b0}};
      slots_q    <= 16'd0;
      perr_q     <= 4'd0;
      mask_q     <= 4'd0;
      value_q    <= 16'd0;
      err_q      <= 4'd0;
      fv_q       <= 1'b0;
    end else begin
      an_s1_q    <= an_s1_d;
      led_s1_q   <= led_s1_d;
      an_s2_q    <= an_s2_d;
      led_s2_q   <= led_s2_d;
      an_prev_q  <= an_prev_d;
      led_prev_q <= led_prev_d;
      cnt_q      <= cnt_d;
      slots_q    <= slots_d;
      perr_q     <= perr_d;
      mask_q     <= mask_d;
      value_q    <= value_d;
      err_q      <= err_d;
      fv_q       <= fv_d;
    end
  end

  assign value       = value_q;
  assign err         = err_q;
  assign frame_valid = fv_q;
  assign digit_mask  = mask_q;

endmodule
